// File: rtl/multiplicador_2_bit.sv
// Unsigned 3x3 multiplier: partial products summed by a ripple half/full-adder array,
// product captured in a 6-bit output register every clock.
module multiplicador_2_bit (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] PORT_A,
    input  logic [2:0] PORT_B,
    output logic [5:0] PORT_OUT
);

    localparam int unsigned OP_W   = 3;
    localparam int unsigned ROW_W  = OP_W + 1;
    localparam int unsigned PROD_W = 2 * OP_W;

    // {carry, sum}
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

    logic [OP_W-1:0]   pp [OP_W];
    logic [1:0]        r1_b0, r1_b1, r1_b2;
    logic [1:0]        r2_b0, r2_b1, r2_b2;
    logic [ROW_W-1:0]  row1;
    logic [PROD_W-1:0] prod_d;
    logic [PROD_W-1:0] prod_q;

    // Row 1 adds pp[1] to pp[0]>>1; row 2 adds pp[2] to row1>>1; carry ripples to bit 5.
    always_comb begin
        for (int i = 0; i < int'(OP_W); i++) begin
            pp[i] = PORT_A & {OP_W{PORT_B[i]}};
        end

        r1_b0 = half_add(pp[0][1], pp[1][0]);
        r1_b1 = full_add(pp[0][2], pp[1][1], r1_b0[1]);
        r1_b2 = half_add(pp[1][2], r1_b1[1]);
        row1  = {r1_b2[1], r1_b2[0], r1_b1[0], r1_b0[0]};

        r2_b0 = half_add(row1[1], pp[2][0]);
        r2_b1 = full_add(row1[2], pp[2][1], r2_b0[1]);
        r2_b2 = full_add(row1[3], pp[2][2], r2_b1[1]);

        prod_d = {r2_b2[1], r2_b2[0], r2_b1[0], r2_b0[0], row1[0], pp[0][0]};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prod_q <= PROD_W'(0);
        end else begin
            prod_q <= prod_d;
        end
    end

    assign PORT_OUT = prod_q;

endmodule

// File: tb/tb_multiplicador_2_bit.sv
// Self-checking bench for multiplicador_2_bit: vector table, exhaustive sweep and
// reset/latency sequences, with expected products queued at drive time.
module tb_multiplicador_2_bit;

    logic       CLK;
    logic       RST_N;
    logic [2:0] PORT_A;
    logic [2:0] PORT_B;
    logic [5:0] PORT_OUT;

    int n_vec = 0;
    int n_err = 0;
    logic [5:0] exp_q [$];

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [5:0] prod;
    } vec_t;

    vec_t vecs [10];

    multiplicador_2_bit dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .PORT_A   (PORT_A),
        .PORT_B   (PORT_B),
        .PORT_OUT (PORT_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [5:0] exp);
        n_vec++;
        if (PORT_OUT !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, PORT_OUT, exp, $time);
        end
    endtask

    // Drive a pair after the falling edge, queue its product, compare just after the rising edge.
    task automatic apply(input logic [2:0] a, input logic [2:0] b, input logic [5:0] exp,
                         input string name);
        logic [5:0] e;
        @(negedge CLK);
        PORT_A = a;
        PORT_B = b;
        exp_q.push_back(exp);
        @(posedge CLK);
        #1;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %0d", name, PORT_OUT);
        end else begin
            e = exp_q.pop_front();
            check(name, e);
        end
    endtask

    initial begin
        vecs[0] = '{3'd0, 3'd7, 6'd0};
        vecs[1] = '{3'd5, 3'd1, 6'd5};
        vecs[2] = '{3'd1, 3'd6, 6'd6};
        vecs[3] = '{3'd4, 3'd4, 6'd16};
        vecs[4] = '{3'd3, 3'd5, 6'd15};
        vecs[5] = '{3'd6, 3'd7, 6'd42};
        vecs[6] = '{3'd7, 3'd7, 6'd49};
        vecs[7] = '{3'd7, 3'd0, 6'd0};
        vecs[8] = '{3'd2, 3'd6, 6'd12};
        vecs[9] = '{3'd5, 3'd6, 6'd30};

        RST_N  = 1'b0;
        PORT_A = 3'd7;
        PORT_B = 3'd7;

        #2;
        check("reset_initial", 6'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            check("reset_held", 6'd0);
        end

        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("reset_release_7x7", 6'd49);

        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].prod, "table");
        end

        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                apply(3'(a), 3'(b), 6'(a * b), "sweep");
            end
        end

        // Mid-cycle operand change must not reach the output before the next edge.
        apply(3'd2, 3'd3, 6'd6, "latency_pre");
        #2;
        PORT_A = 3'd7;
        #1;
        check("latency_hold", 6'd6);
        @(negedge CLK);
        check("latency_hold_neg", 6'd6);
        @(posedge CLK);
        #1;
        check("latency_post", 6'd21);

        // Asynchronous reset between edges, then release with new operands.
        apply(3'd6, 3'd7, 6'd42, "async_pre");
        #2;
        RST_N = 1'b0;
        #1;
        check("async_assert", 6'd0);
        @(posedge CLK);
        #1;
        check("async_held", 6'd0);
        @(negedge CLK);
        PORT_A = 3'd3;
        PORT_B = 3'd3;
        RST_N  = 1'b1;
        @(posedge CLK);
        #1;
        check("async_release_3x3", 6'd9);

        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) apply(3'd7, 3'd7, 6'd49, "alt_max");
            else            apply(3'd0, 3'd0, 6'd0, "alt_zero");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
